// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [NREG-1:0] pending
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e            ptr_q, ptr_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            a_xfer, b_xfer, issue_xfer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= PTR_A;
      pending_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // The pointer only moves when both sources compete, so a lone source never loses its turn.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    ptr_d   = ptr_q;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (ptr_q == PTR_A) begin
          a_ready = 1'b1;
          ptr_d   = PTR_B;
        end else begin
          b_ready = 1'b1;
          ptr_d   = PTR_A;
        end
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign a_xfer      = a_valid && a_ready;
  assign b_xfer      = b_valid && b_ready;
  assign issue_ready = !reset && ((issue_rd == '0) || !pending_q[issue_rd]);
  assign issue_xfer  = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (a_xfer && (a_rd != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = a_rd;
      wr_data_d = a_data;
    end else if (b_xfer && (b_rd != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = b_rd;
      wr_data_d = b_data;
    end
  end

  // Clear before set: a clear and a set of different registers in one cycle both land.
  always_comb begin
    pending_d = pending_q;
    if (b_xfer) begin
      pending_d[b_rd] = 1'b0;
    end
    if (issue_xfer) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // The write-stage term covers the cycle where a value is granted but not yet in the file.
  assign rs1_busy = (rs1_addr != '0) &&
                    (pending_q[rs1_addr] || (wr_en_q && (wr_addr_q == rs1_addr)));
  assign rs2_busy = (rs2_addr != '0) &&
                    (pending_q[rs2_addr] || (wr_en_q && (wr_addr_q == rs2_addr)));

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1_addr, rs2_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, issue_ready, rs1_busy, rs2_busy, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // B must only write back registers that decode marked pending.
  always @(posedge clock) begin
    if (!reset && b_valid && b_ready && b_rd != 5'd0) begin
      n_cmp++;
      assert (pending[b_rd] === 1'b1) else begin
        n_fail++;
        $error("FAIL b_protocol: pending[%0d] observed %b expected 1", b_rd, pending[b_rd]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; issue_valid = 1'b0;
    a_rd = 5'd1; b_rd = 5'd2; issue_rd = 5'd4; rs1_addr = 5'd0; rs2_addr = 5'd0;
    a_data = 32'h0; b_data = 32'h0;
    #12;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_issue_ready", issue_ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_pending", pending, 32'h0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("idle_wr_en", wr_en, 1'b0);
    chk("idle_pending", pending, 32'h0);
    chk("idle_issue_ready", issue_ready, 1'b1);
    chk("idle_rs1_busy", rs1_busy, 1'b0);
    chk("idle_rs2_busy", rs2_busy, 1'b0);

    // A alone
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234; rs1_addr = 5'd5;
    #1;
    chk("a1_ready", a_ready, 1'b1);
    chk("a1_rs1_busy_pre", rs1_busy, 1'b0);
    tick();
    a_valid = 1'b0;
    #1;
    chk("a1_wr_en", wr_en, 1'b1);
    chk("a1_wr_addr", wr_addr, 5'd5);
    chk("a1_wr_data", wr_data, 32'h1234);
    chk("a1_rs1_busy", rs1_busy, 1'b1);
    tick();
    chk("a1_wr_en_off", wr_en, 1'b0);
    chk("a1_wr_addr_hold", wr_addr, 5'd5);
    chk("a1_wr_data_hold", wr_data, 32'h1234);
    chk("a1_rs1_busy_off", rs1_busy, 1'b0);

    // Mark rd 2 and 4 pending for the contested B writes
    issue_valid = 1'b1; issue_rd = 5'd2;
    tick();
    issue_rd = 5'd4;
    tick();
    issue_valid = 1'b0;
    #1;
    chk("iss24_pending", pending, 32'h0000_0014);
    rs2_addr = 5'd2;
    #1;
    chk("iss2_rs2_busy", rs2_busy, 1'b1);

    // Contested: A,B,A,B then A alone
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hB2;
    #1;
    chk("c1_a_ready", a_ready, 1'b1);
    chk("c1_b_ready", b_ready, 1'b0);
    tick();
    a_data = 32'hA3;
    #1;
    chk("c2_b_ready", b_ready, 1'b1);
    chk("c2_a_ready", a_ready, 1'b0);
    chk("c2_wr_addr", wr_addr, 5'd1);
    chk("c2_wr_data", wr_data, 32'hA1);
    tick();
    b_rd = 5'd4; b_data = 32'hB4;
    #1;
    chk("c3_a_ready", a_ready, 1'b1);
    chk("c3_wr_en", wr_en, 1'b1);
    chk("c3_wr_addr", wr_addr, 5'd2);
    chk("c3_wr_data", wr_data, 32'hB2);
    chk("c3_pending", pending, 32'h0000_0010);
    tick();
    a_data = 32'hA5;
    #1;
    chk("c4_b_ready", b_ready, 1'b1);
    chk("c4_wr_data", wr_data, 32'hA3);
    tick();
    b_valid = 1'b0;
    #1;
    chk("c5_a_ready", a_ready, 1'b1);
    chk("c5_wr_addr", wr_addr, 5'd4);
    chk("c5_wr_data", wr_data, 32'hB4);
    chk("c5_pending", pending, 32'h0);
    tick();
    a_valid = 1'b0;
    #1;
    chk("c6_wr_en", wr_en, 1'b1);
    chk("c6_wr_data", wr_data, 32'hA5);
    tick();

    // RAW/WAW on rd 7
    issue_valid = 1'b1; issue_rd = 5'd7; rs2_addr = 5'd7;
    #1;
    chk("i7_ready", issue_ready, 1'b1);
    tick();
    chk("i7_pending", pending, 32'h0000_0080);
    chk("i7_rs2_busy", rs2_busy, 1'b1);
    chk("i7_second_stall", issue_ready, 1'b0);
    tick();
    chk("i7_still_stall", issue_ready, 1'b0);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hDEAD;
    #1;
    chk("b7_ready", b_ready, 1'b1);
    chk("b7_no_forward", issue_ready, 1'b0);
    tick();
    b_valid = 1'b0;
    #1;
    chk("b7_pending_clr", pending, 32'h0);
    chk("b7_issue_ready", issue_ready, 1'b1);
    chk("b7_wr_en", wr_en, 1'b1);
    chk("b7_wr_addr", wr_addr, 5'd7);
    chk("b7_wr_data", wr_data, 32'hDEAD);
    chk("b7_rs2_busy_wb", rs2_busy, 1'b1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("i7_reissued", pending, 32'h0000_0080);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h7;
    tick();
    b_valid = 1'b0;
    #1;
    chk("b7b_pending_clr", pending, 32'h0);

    // rd 0 everywhere
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    #1;
    chk("z_a_ready", a_ready, 1'b1);
    chk("z_issue_ready", issue_ready, 1'b1);
    tick();
    a_valid = 1'b0; issue_valid = 1'b0;
    #1;
    chk("z_wr_en", wr_en, 1'b0);
    chk("z_pending", pending, 32'h0);
    chk("z_rs1_busy", rs1_busy, 1'b0);

    // Async reset with a B write in flight and pointer at B
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h33;
    #1;
    chk("r_pending_pre", pending, 32'h0000_0048);
    chk("r_a_first", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    tick();
    b_valid = 1'b0;
    #1;
    chk("r_b_inflight", wr_en, 1'b1);
    chk("r_b_inflight_addr", wr_addr, 5'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("r_wr_en_drop", wr_en, 1'b0);
    chk("r_pending_clr", pending, 32'h0);
    tick();
    reset = 1'b0;
    a_valid = 1'b1; a_rd = 5'd1; b_valid = 1'b1; b_rd = 5'd9;
    #1;
    chk("r_ptr_a_a", a_ready, 1'b1);
    chk("r_ptr_a_b", b_ready, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Source A: in-order execute pipe.
  - Source B: long-latency unit (load/multiply/divide).
- Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards against outstanding B operations.
- Sits between the writeback sources and the register file's writeEn/address_wr/write_data inputs.

Parameters:
- XLEN, 32, data width of write_data and source data.
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width; must equal log2(NREG).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- a_valid  input  1  source A has a writeback.
- a_rd  input  AW  source A destination register.
- a_data  input  XLEN  source A result.
- a_ready  output  1  source A granted this cycle.
- b_valid  input  1  source B has a writeback.
- b_rd  input  AW  source B destination register.
- b_data  input  XLEN  source B result.
- b_ready  output  1  source B granted this cycle.
- issue_valid  input  1  decode issues a B-bound op.
- issue_rd  input  AW  destination of the issued op.
- issue_ready  output  1  issue accepted; low means stall.
- rs1_addr  input  AW  decode source operand 1.
- rs2_addr  input  AW  decode source operand 2.
- rs1_busy  output  1  rs1 value not yet in the register file.
- rs2_busy  output  1  rs2 value not yet in the register file.
- wr_en  output  1  to register file writeEn.
- wr_addr  output  AW  to register file address_wr.
- wr_data  output  XLEN  to register file write_data.
- pending  output  NREG  scoreboard mask, for debug.

Behaviour:
- Reset (async, immediate): wr_en=0, wr_addr=0, wr_data=0, pending=0, round-robin pointer=A. During reset a_ready, b_ready and issue_ready are 0.
- Arbitration (combinational, one grant per cycle):
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the side the pointer names, then flip the pointer to the other side.
  - Pointer changes only on a contested grant.
- a_ready/b_ready = grant; transfer occurs when valid && ready at the rising edge.
- Sources must hold valid, rd and data stable until ready.
- Write stage (registered, latency 1):
  - A granted transfer at edge N drives wr_en=1, wr_addr=rd, wr_data=data for cycle N+1 only.
  - No transfer -> wr_en=0 next cycle; wr_addr/wr_data hold their last values.
- rd=0 transfers are accepted (ready asserted) but produce wr_en=0.
- Scoreboard:
  - Accepted issue with issue_rd!=0 sets pending[issue_rd] at the edge.
  - A B transfer clears pending[b_rd] at the edge. A transfers never touch pending.
  - Bit 0 is always 0.
- issue_ready = !reset && (issue_rd==0 || !pending[issue_rd]).
  - A same-cycle B clear of the same register is not forwarded; issue waits one cycle.
- Simultaneous issue set and B clear of different registers: both take effect.
- rsN_busy (combinational) = (rsN!=0) && (pending[rsN] || (wr_en && wr_addr==rsN)).
  - This covers the one-cycle window between grant and the register-file write.
- B transfer to a register with no pending bit: write proceeds normally; pending is unchanged. This is a protocol violation and must be flagged by a bench assertion.
- Reset mid-operation:
  - Any in-flight write is dropped (wr_en=0).
  - The scoreboard is cleared.
  - The pointer returns to A.

Test Plan:
- Reset then idle -> wr_en=0, pending=0, issue_ready=1, rs1_busy=rs2_busy=0.
- A alone, rd=5, data=0x1234 at cycle 1 -> a_ready=1 in cycle 1; wr_en=1, wr_addr=5, wr_data=0x1234 in cycle 2 only; rs1_addr=5 gives rs1_busy=1 in cycle 2, 0 in cycle 3.
- A and B both valid for 4 cycles (rd 1/2) -> grants alternate A,B,A,B; each source held until granted; a write every cycle.
- Issue rd=7 -> pending[7]=1, rs2_addr=7 busy; second issue rd=7 -> issue_ready=0 until B writes rd=7 (0xDEAD); pending[7] clears; busy held one more cycle by write stage; issue accepted the cycle after.
- A rd=0 and issue rd=0 -> a_ready=1, wr_en stays 0, pending unchanged, issue_ready=1.
- Issue rd=3, then assert reset asynchronously mid-cycle while a B write is in flight -> wr_en drops immediately, pending=0, pointer=A after release.
